// File: rtl/i2c_pkg.sv
// i2c_pkg: state type and bus constants shared by the I2C byte receive and transmit paths.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SHIFT     = 2'd2,
    ACK       = 2'd3
  } i2c_tx_state_e;

  localparam int   I2C_BITS_PER_BYTE = 8;
  localparam logic I2C_ACK           = 1'b0;
  localparam logic I2C_NACK          = 1'b1;

endpackage

// File: rtl/scl_edge_detect.sv
// scl_edge_detect: one-register SCL edge detector; scl_q idles high like the bus.
module scl_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  output logic scl_q,
  output logic scl_rise,
  output logic scl_fall
);

  always_ff @(posedge clk) begin
    if (reset) scl_q <= 1'b1;
    else       scl_q <= scl;
  end

  assign scl_rise = ~scl_q & scl;
  assign scl_fall = scl_q & ~scl;

endmodule

// File: rtl/i2c_byte_transmitter.sv
// i2c_byte_transmitter: shifts read bytes out MSB-first on SDA and samples the controller ACK/NACK.
// Define I2C_TX_CLOCK_STRETCH_EN to hold SCL low while waiting for data instead of flagging underrun.
//   state     | meaning
//   IDLE      | bus not ours, SDA released
//   WAIT_DATA | SCL low, waiting for a tx_data handshake
//   SHIFT     | driving the 8 data bits, advancing on each SCL fall
//   ACK       | SDA released, sampling controller ACK/NACK
module i2c_byte_transmitter
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       start,
  input  logic       abort,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       underrun
);

  logic          scl_q;
  logic          scl_rise;
  logic          scl_fall;
  logic          accept;
  i2c_tx_state_e state_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_cnt_q;
  logic          ack_nack_q;
  logic          sda_oe_q;
  logic          done_q;
  logic          nack_q;
  logic          underrun_q;

  scl_edge_detect u_scl_edge (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .scl_q    (scl_q),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  // Only take a byte while SCL is low so the MSB is on SDA before the next rise.
  assign tx_ready = (state_q == WAIT_DATA) && !scl;
  assign accept   = tx_ready && tx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ack_nack_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            sda_oe_q <= 1'b0;
            if (start) state_q <= WAIT_DATA;
          end
          WAIT_DATA: begin
            if (accept) begin
              shreg_q   <= tx_data;
              bit_cnt_q <= 3'(I2C_BITS_PER_BYTE - 1);
              sda_oe_q  <= ~tx_data[7];
              state_q   <= SHIFT;
            end
`ifndef I2C_TX_CLOCK_STRETCH_EN
            else if (scl_rise) begin
              underrun_q <= 1'b1;
              sda_oe_q   <= 1'b0;
              state_q    <= IDLE;
            end
`endif
          end
          SHIFT: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                state_q  <= ACK;
              end else begin
                shreg_q   <= shreg_q << 1;
                bit_cnt_q <= bit_cnt_q - 3'd1;
                sda_oe_q  <= ~shreg_q[6];
              end
            end
          end
          ACK: begin
            if (scl_rise) begin
              ack_nack_q <= sda;
            end else if (scl_fall) begin
              done_q  <= 1'b1;
              nack_q  <= ack_nack_q;
              state_q <= (ack_nack_q == I2C_NACK) ? IDLE : WAIT_DATA;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef I2C_TX_CLOCK_STRETCH_EN
  logic scl_oe_q;

  always_ff @(posedge clk) begin
    if (reset) scl_oe_q <= 1'b0;
    else       scl_oe_q <= !abort && (state_q == WAIT_DATA) && !scl_q && !accept;
  end

  assign scl_oe = scl_oe_q;
`else
  logic unused_scl_q;
  assign unused_scl_q = scl_q;
  assign scl_oe       = 1'b0;
`endif

  assign sda_oe   = sda_oe_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign nack     = nack_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2c_byte_transmitter.sv
// Bench for i2c_byte_transmitter: models an I2C controller reading bytes over open-drain SCL/SDA.
module tb_i2c_byte_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ctl_scl;
  logic       ctl_sda_low;
  logic       scl;
  logic       sda;
  logic       tx_ready;
  logic       sda_oe;
  logic       scl_oe;
  logic       busy;
  logic       done;
  logic       nack;
  logic       underrun;

  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         underrun_cnt = 0;
  logic       prev_oe = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_und = 1'b0;
  logic [7:0] src_q[$];

  typedef struct {
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;
  vec_t vecs[4];

  // Wired-AND bus: either side can pull a line low.
  assign scl = ctl_scl & ~scl_oe;
  assign sda = ~(sda_oe | ctl_sda_low);

  always #5 clk = ~clk;

  i2c_byte_transmitter dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .start    (start),
    .abort    (abort),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .sda_oe   (sda_oe),
    .scl_oe   (scl_oe),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .underrun (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic src_drive();
    if (src_q.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = src_q[0];
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic step();
    logic hs, scl_b, quiet;
    #1;
    hs    = tx_valid & tx_ready;
    scl_b = scl;
    quiet = abort | reset;
    @(posedge clk);
    #1;
    if (sda_oe !== prev_oe && !quiet) chk("sda_change_while_scl_high", 32'(scl_b), 32'd0);
    if (prev_done === 1'b1) chk("done_single_cycle", 32'(done), 32'd0);
    if (prev_und === 1'b1) chk("underrun_single_cycle", 32'(underrun), 32'd0);
    if (done === 1'b1) done_cnt++;
    if (underrun === 1'b1) underrun_cnt++;
    prev_oe   = sda_oe;
    prev_done = done;
    prev_und  = underrun;
    if (hs === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
    src_drive();
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    #1;
    while (scl !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (scl !== 1'b1) chk("scl_release_timeout", 32'(scl), 32'd1);
  endtask

  task automatic begin_read();
    ctl_scl = 1'b0;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_read();
    repeat (2) step();
    ctl_scl = 1'b1;
    repeat (4) step();
    chk("idle_after_txn", 32'(busy), 32'd0);
  endtask

  // One byte plus ACK slot as the controller sees it; SCL is low on entry and exit.
  task automatic xfer_byte(input logic [7:0] exp_b, input bit ctl_nack, input int lo, input int hi,
                           input bit first_high);
    logic [7:0] got;
    got = '0;
    for (int i = 0; i < 9; i++) begin
      ctl_sda_low = (i == 8) && !ctl_nack;
      if (!(first_high && i == 0)) repeat (lo) step();
      ctl_scl = 1'b1;
      wait_scl_high();
      if (i < 8) got[7-i] = sda;
      else chk("ack_slot_sda_oe", 32'(sda_oe), 32'd0);
      repeat (hi) step();
      ctl_scl = 1'b0;
    end
    ctl_sda_low = 1'b0;
    step();
    chk("byte_on_sda", 32'(got), 32'(exp_b));
    chk("done_pulse", 32'(done), 32'd1);
    chk("nack_flag", 32'(nack), 32'(ctl_nack));
    if (ctl_nack) begin
      step();
      chk("busy_after_nack", 32'(busy), 32'd0);
    end else begin
      chk("tx_ready_reassert", 32'(tx_ready), 32'd1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int         sent, nb, d_before, u_before;
    logic [7:0] bytes[$];
    logic [7:0] b;

    vecs[0] = '{1, 8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{2, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{1, 8'hC3, 8'h00, 8'hC3, 8'h00};
    vecs[3] = '{2, 8'h81, 8'h7E, 8'h81, 8'h7E};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    ctl_scl = 1'b1; ctl_sda_low = 1'b0;
    src_drive();
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("reset_tx_ready", 32'(tx_ready), 32'd0);
    chk("reset_sda_oe", 32'(sda_oe), 32'd0);
    chk("reset_scl_oe", 32'(scl_oe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_nack", 32'(nack), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    for (int i = 0; i < 6; i++) begin
      ctl_scl = ~ctl_scl;
      repeat (5) step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sda_oe", 32'(sda_oe), 32'd0);
    end

    for (int v = 0; v < 4; v++) begin
      src_q.push_back(vecs[v].d0);
      if (vecs[v].nb == 2) src_q.push_back(vecs[v].d1);
      src_drive();
      begin_read();
      xfer_byte(vecs[v].exp0, vecs[v].nb == 1, 5, 4, 1'b0);
      if (vecs[v].nb == 2) xfer_byte(vecs[v].exp1, 1'b1, 5, 4, 1'b0);
      end_read();
    end

    // Abort after three bits of 0x3C: no done, bus released.
    src_q.push_back(8'h3C);
    src_drive();
    begin_read();
    for (int i = 0; i < 3; i++) begin
      repeat (5) step();
      ctl_scl = 1'b1;
      wait_scl_high();
      repeat (4) step();
      ctl_scl = 1'b0;
    end
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_sda_oe", 32'(sda_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    d_before = done_cnt;
    for (int i = 0; i < 9; i++) begin
      repeat (5) step();
      ctl_scl = 1'b1;
      repeat (4) step();
      ctl_scl = 1'b0;
    end
    chk("abort_no_done", 32'(done_cnt - d_before), 32'd0);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    ctl_scl = 1'b1;
    repeat (4) step();

    // Late data after start.
    begin_read();
`ifdef I2C_TX_CLOCK_STRETCH_EN
    repeat (4) step();
    ctl_scl = 1'b1;
    for (int i = 4; i < 20; i++) begin
      step();
      chk("stretch_scl_oe", 32'(scl_oe), 32'd1);
    end
    src_q.push_back(8'h81);
    src_drive();
    step();
    chk("stretch_release", 32'(scl_oe), 32'd0);
    xfer_byte(8'h81, 1'b1, 5, 4, 1'b1);
    end_read();
    chk("stretch_no_underrun", 32'(underrun_cnt), 32'd0);
`else
    repeat (9) step();
    ctl_scl = 1'b1;
    step();
    chk("underrun_pulse", 32'(underrun), 32'd1);
    chk("underrun_busy", 32'(busy), 32'd0);
    chk("underrun_sda_oe", 32'(sda_oe), 32'd0);
    step();
    chk("underrun_cleared", 32'(underrun), 32'd0);
    repeat (4) step();
`endif

    // 100 random bytes with random SCL timing.
    sent = 0;
    d_before = done_cnt;
    u_before = underrun_cnt;
    while (sent < 100) begin
      nb = int'($urandom_range(1, 6));
      if (nb > 100 - sent) nb = 100 - sent;
      bytes.delete();
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        bytes.push_back(b);
        src_q.push_back(b);
      end
      src_drive();
      begin_read();
      for (int k = 0; k < nb; k++)
        xfer_byte(bytes[k], k == nb - 1, int'($urandom_range(4, 8)), int'($urandom_range(2, 6)), 1'b0);
      end_read();
      sent += nb;
    end
    chk("random_done_count", 32'(done_cnt - d_before), 32'd100);
    chk("random_no_underrun", 32'(underrun_cnt - u_before), 32'd0);
    chk("random_source_drained", 32'(src_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
